// File: rtl/lc2k_control_fsm.sv
// -----------------------------------------------------------------------------
// lc2k_control_fsm
//
// Multi-cycle fetch/decode/control sequencer for the LC2K CPU. Owns the PC and
// instruction register, runs the memory handshake for instruction fetch and
// lw/sw data accesses, drives the register file's read/write selects and
// write strobe, and steers the ALU and writeback muxes for all eight opcodes.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-high reset
//   mem_rdata[31:0]          memory read data (instruction or lw data)
//   mem_ready                memory completes the current request this cycle
//   reg_a_value[31:0]        register file regA read value (jalr target)
//   regs_equal               datapath compare, regA value == regB value
//   mem_req                  memory request
//   mem_we                   write request (sw), valid with mem_req
//   mem_addr_sel             memory address mux: 0 = PC, 1 = ALU result
//   pc[PC_WIDTH-1:0]         current PC
//   read_regA[2:0]           IR[21:19]
//   read_regB[2:0]           IR[18:16]
//   write_reg[2:0]           destination register
//   CONTROL_ENABLE_REG_WRITE one-cycle register write strobe
//   alu_op[1:0]              00 add, 01 nor, 10 add regA + offset
//   offset_sext[31:0]        sign-extended IR[15:0]
//   wb_sel[1:0]              00 ALU, 01 mem_rdata, 10 PC (link)
//   halted                   halt retired; sticky until reset
//   instr_count[CNT_WIDTH-1:0] retired instructions, including halt
//   dbg_state[2:0]           current FSM state (FETCH=0 DECODE=1 EXEC=2
//                            MEM=3 WB=4 HALTED=5)
//
// Memory handshake (valid/ready): a transfer completes on a rising clk edge
// where mem_req and mem_ready are both high. Once mem_req is raised it stays
// high, with mem_we and mem_addr_sel unchanged, until that edge. mem_ready
// while mem_req is low is ignored.
// -----------------------------------------------------------------------------
module lc2k_control_fsm #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    input  logic [31:0]          reg_a_value,
    input  logic                 regs_equal,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [2:0]           read_regA,
    output logic [2:0]           read_regB,
    output logic [2:0]           write_reg,
    output logic                 CONTROL_ENABLE_REG_WRITE,
    output logic [1:0]           alu_op,
    output logic [31:0]          offset_sext,
    output logic [1:0]           wb_sel,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_NOR = 2'b01;
    localparam logic [1:0] ALU_OFS = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    state_t              state;
    logic [31:0]         ir;
    logic [PC_WIDTH-1:0] jalr_target;
    logic [2:0]          opcode;

    assign opcode      = ir[24:22];
    assign read_regA   = ir[21:19];
    assign read_regB   = ir[18:16];
    assign offset_sext = {{16{ir[15]}}, ir[15:0]};
    assign dbg_state   = state;

    // IR[31:25] carries no meaning, and only the low PC_WIDTH bits of regA
    // form a jalr target.
    logic unused_bits;
    assign unused_bits = ^{ir[31:25], reg_a_value[31:PC_WIDTH]};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= S_FETCH;
            ir                       <= '0;
            pc                       <= '0;
            jalr_target              <= '0;
            mem_req                  <= 1'b0;
            mem_we                   <= 1'b0;
            mem_addr_sel             <= 1'b0;
            write_reg                <= '0;
            CONTROL_ENABLE_REG_WRITE <= 1'b0;
            alu_op                   <= '0;
            wb_sel                   <= '0;
            halted                   <= 1'b0;
            instr_count              <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    mem_we       <= 1'b0;
                    mem_addr_sel <= 1'b0;
                    // First FETCH cycle after reset has mem_req low, so the
                    // request is raised here and the transfer waits a cycle.
                    if (mem_req && mem_ready) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end

                S_DECODE: begin
                    pc <= pc + PC_WIDTH'(1);
                    if (opcode == OP_HALT) begin
                        halted      <= 1'b1;
                        instr_count <= sat_inc(instr_count);
                        state       <= S_HALTED;
                    end else begin
                        case (opcode)
                            OP_NOR:       alu_op <= ALU_NOR;
                            OP_LW, OP_SW: alu_op <= ALU_OFS;
                            default:      alu_op <= ALU_ADD;
                        endcase
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_NOR: begin
                            write_reg                <= ir[2:0];
                            wb_sel                   <= WB_ALU;
                            CONTROL_ENABLE_REG_WRITE <= (ir[2:0] != 3'd0);
                            state                    <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            mem_req      <= 1'b1;
                            mem_addr_sel <= 1'b1;
                            mem_we       <= (opcode == OP_SW);
                            state        <= S_MEM;
                        end
                        OP_BEQ: begin
                            // PC already points at the next instruction.
                            if (regs_equal) begin
                                pc <= pc + offset_sext[PC_WIDTH-1:0];
                            end
                            instr_count <= sat_inc(instr_count);
                            mem_req     <= 1'b1;
                            state       <= S_FETCH;
                        end
                        OP_JALR: begin
                            // Latched before the link write so jalr rX,rX
                            // jumps to the old regA value.
                            jalr_target              <= reg_a_value[PC_WIDTH-1:0];
                            write_reg                <= ir[18:16];
                            wb_sel                   <= WB_LINK;
                            CONTROL_ENABLE_REG_WRITE <= (ir[18:16] != 3'd0);
                            state                    <= S_WB;
                        end
                        default: begin
                            // noop (halt never reaches EXEC)
                            instr_count <= sat_inc(instr_count);
                            mem_req     <= 1'b1;
                            state       <= S_FETCH;
                        end
                    endcase
                end

                S_MEM: begin
                    if (mem_ready) begin
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        if (opcode == OP_SW) begin
                            instr_count <= sat_inc(instr_count);
                            mem_req     <= 1'b1;
                            state       <= S_FETCH;
                        end else begin
                            // The loaded word is routed from mem_rdata through
                            // the writeback mux.
                            mem_req                  <= 1'b0;
                            write_reg                <= ir[18:16];
                            wb_sel                   <= WB_MEM;
                            CONTROL_ENABLE_REG_WRITE <= (ir[18:16] != 3'd0);
                            state                    <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    CONTROL_ENABLE_REG_WRITE <= 1'b0;
                    // The link value (pc) is written this cycle; the jump
                    // takes effect at the same edge.
                    if (opcode == OP_JALR) begin
                        pc <= jalr_target;
                    end
                    instr_count <= sat_inc(instr_count);
                    mem_req     <= 1'b1;
                    state       <= S_FETCH;
                end

                S_HALTED: begin
                    mem_req                  <= 1'b0;
                    mem_we                   <= 1'b0;
                    mem_addr_sel             <= 1'b0;
                    CONTROL_ENABLE_REG_WRITE <= 1'b0;
                end

                default: begin
                    state   <= S_FETCH;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc2k_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_lc2k_control_fsm
//
// Directed bench for lc2k_control_fsm. Instructions are fed by hand through
// the fetch handshake and every expected value is written out as a constant
// worked from the LC2K encoding. Inputs change 1 time unit after the rising
// edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_lc2k_control_fsm;

    localparam int PC_WIDTH  = 16;
    localparam int CNT_WIDTH = 32;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;

    localparam logic [31:0] I_ADD_R1   = 32'h0000_A001; // add, dest r1
    localparam logic [31:0] I_LW       = 32'h0081_0004; // lw regA=0 regB=1 off 4
    localparam logic [31:0] I_SW       = 32'h00C1_0007; // sw regA=0 regB=1 off 7
    localparam logic [31:0] I_NOOP     = 32'h01C0_0000;
    localparam logic [31:0] I_BEQ_M3   = 32'h0100_FFFD; // beq off -3
    localparam logic [31:0] I_JALR_R2  = 32'h0152_0000; // jalr regA=2 regB=2
    localparam logic [31:0] I_ADD_R0   = 32'h0009_0000; // add r1,r1 -> r0
    localparam logic [31:0] I_ADD_R3   = 32'h0000_0003; // add r0,r0 -> r3
    localparam logic [31:0] I_HALT     = 32'h0180_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0]          mem_rdata;
    logic                 mem_ready;
    logic [31:0]          reg_a_value;
    logic                 regs_equal;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_addr_sel;
    logic [PC_WIDTH-1:0]  pc;
    logic [2:0]           read_regA;
    logic [2:0]           read_regB;
    logic [2:0]           write_reg;
    logic                 CONTROL_ENABLE_REG_WRITE;
    logic [1:0]           alu_op;
    logic [31:0]          offset_sext;
    logic [1:0]           wb_sel;
    logic                 halted;
    logic [CNT_WIDTH-1:0] instr_count;
    logic [2:0]           dbg_state;

    lc2k_control_fsm #(
        .PC_WIDTH (PC_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .mem_rdata               (mem_rdata),
        .mem_ready               (mem_ready),
        .reg_a_value             (reg_a_value),
        .regs_equal              (regs_equal),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr_sel            (mem_addr_sel),
        .pc                      (pc),
        .read_regA               (read_regA),
        .read_regB               (read_regB),
        .write_reg               (write_reg),
        .CONTROL_ENABLE_REG_WRITE(CONTROL_ENABLE_REG_WRITE),
        .alu_op                  (alu_op),
        .offset_sext             (offset_sext),
        .wb_sel                  (wb_sel),
        .halted                  (halted),
        .instr_count             (instr_count),
        .dbg_state               (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH with mem_req already high; leaves the DUT in DECODE.
    task automatic fetch(input logic [31:0] instr);
        check("fetch_state", 32'(dbg_state), 32'(ST_FETCH));
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_sel", 32'(mem_addr_sel), 32'd0);
        mem_rdata = instr;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        check("decode_state", 32'(dbg_state), 32'(ST_DECODE));
    endtask

    task automatic do_noop();
        fetch(I_NOOP);
        tick();
        tick();
        check("noop_done", 32'(dbg_state), 32'(ST_FETCH));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        mem_rdata   = '0;
        mem_ready   = 1'b0;
        reg_a_value = '0;
        regs_equal  = 1'b0;

        // Reset state and reset during FETCH with mem_ready low.
        tick();
        tick();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_FETCH));
        check("rst_cnt", instr_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_req", 32'(mem_req), 32'd1);
        tick();
        check("fetch_wait", 32'(dbg_state), 32'(ST_FETCH));
        #3 reset = 1'b1;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_pc", 32'(pc), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'(ST_FETCH));
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("rel_req", 32'(mem_req), 32'd1);
        check("rel_sel", 32'(mem_addr_sel), 32'd0);

        // add r1, mem_ready effectively high: strobe in cycle 4.
        fetch(I_ADD_R1);
        check("add_dec_pc", 32'(pc), 32'd0);
        check("add_dec_req", 32'(mem_req), 32'd0);
        tick();
        check("add_exec_pc", 32'(pc), 32'd1);
        check("add_exec_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        tick();
        check("add_wb_state", 32'(dbg_state), 32'(ST_WB));
        check("add_wb_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd1);
        check("add_wb_wreg", 32'(write_reg), 32'd1);
        check("add_wb_alu", 32'(alu_op), 32'd0);
        check("add_wb_sel", 32'(wb_sel), 32'd0);
        check("add_wb_pc", 32'(pc), 32'd1);
        check("add_offset", offset_sext, 32'hFFFF_A001);
        tick();
        check("add_cnt", instr_count, 32'd1);
        check("add_strobe_off", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);

        // lw with two wait cycles in MEM; mem_ready during DECODE is ignored.
        fetch(I_LW);
        check("lw_rega", 32'(read_regA), 32'd0);
        check("lw_regb", 32'(read_regB), 32'd1);
        mem_ready = 1'b1;
        tick();
        check("lw_exec_state", 32'(dbg_state), 32'(ST_EXEC));
        check("lw_exec_req", 32'(mem_req), 32'd0);
        check("lw_alu", 32'(alu_op), 32'd2);
        mem_ready = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            tick();
            check("lw_mem_state", 32'(dbg_state), 32'(ST_MEM));
            check("lw_mem_req", 32'(mem_req), 32'd1);
            check("lw_mem_sel", 32'(mem_addr_sel), 32'd1);
            check("lw_mem_we", 32'(mem_we), 32'd0);
            if (c == 6) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        check("lw_wb_state", 32'(dbg_state), 32'(ST_WB));
        check("lw_wb_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd1);
        check("lw_wb_wreg", 32'(write_reg), 32'd1);
        check("lw_wb_sel", 32'(wb_sel), 32'd1);
        check("lw_wb_req", 32'(mem_req), 32'd0);
        tick();
        check("lw_pc", 32'(pc), 32'd2);
        check("lw_cnt", instr_count, 32'd2);

        // sw with mem_ready high: 4 cycles, no strobe.
        fetch(I_SW);
        mem_ready = 1'b1;
        tick();
        check("sw_alu", 32'(alu_op), 32'd2);
        tick();
        check("sw_mem_state", 32'(dbg_state), 32'(ST_MEM));
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_mem_sel", 32'(mem_addr_sel), 32'd1);
        check("sw_mem_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        tick();
        mem_ready = 1'b0;
        check("sw_done_state", 32'(dbg_state), 32'(ST_FETCH));
        check("sw_done_we", 32'(mem_we), 32'd0);
        check("sw_done_sel", 32'(mem_addr_sel), 32'd0);
        check("sw_pc", 32'(pc), 32'd3);
        check("sw_cnt", instr_count, 32'd3);

        // beq taken backward at pc=5.
        do_noop();
        do_noop();
        check("pre_beq_pc", 32'(pc), 32'd5);
        check("pre_beq_cnt", instr_count, 32'd5);
        regs_equal = 1'b1;
        fetch(I_BEQ_M3);
        tick();
        check("beq_t_exec_pc", 32'(pc), 32'd6);
        check("beq_t_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        tick();
        regs_equal = 1'b0;
        check("beq_t_pc", 32'(pc), 32'd3);
        check("beq_t_cnt", instr_count, 32'd6);
        check("beq_t_strobe2", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);

        // Same beq not taken.
        do_noop();
        do_noop();
        check("pre_beq2_pc", 32'(pc), 32'd5);
        fetch(I_BEQ_M3);
        tick();
        check("beq_n_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        tick();
        check("beq_n_pc", 32'(pc), 32'd6);
        check("beq_n_cnt", instr_count, 32'd9);

        // jalr r2,r2 at pc=10 with regA value 20.
        for (int k = 0; k < 4; k++) do_noop();
        check("pre_jalr_pc", 32'(pc), 32'd10);
        fetch(I_JALR_R2);
        check("jalr_rega", 32'(read_regA), 32'd2);
        check("jalr_regb", 32'(read_regB), 32'd2);
        reg_a_value = 32'd20;
        tick();
        tick();
        reg_a_value = 32'd99;
        check("jalr_wb_state", 32'(dbg_state), 32'(ST_WB));
        check("jalr_wb_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd1);
        check("jalr_wb_wreg", 32'(write_reg), 32'd2);
        check("jalr_wb_sel", 32'(wb_sel), 32'd2);
        check("jalr_link", 32'(pc), 32'd11);
        tick();
        check("jalr_pc", 32'(pc), 32'd20);
        check("jalr_cnt", instr_count, 32'd14);

        // add with dest r0: no strobe but still retires.
        fetch(I_ADD_R0);
        tick();
        tick();
        check("r0_wb_state", 32'(dbg_state), 32'(ST_WB));
        check("r0_wb_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        tick();
        check("r0_cnt", instr_count, 32'd15);
        check("r0_pc", 32'(pc), 32'd21);

        // Reset during a strobing WB aborts the strobe immediately.
        fetch(I_ADD_R3);
        tick();
        tick();
        check("r3_wb_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd1);
        check("r3_wb_wreg", 32'(write_reg), 32'd3);
        #3 reset = 1'b1;
        #1;
        check("wb_rst_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        check("wb_rst_pc", 32'(pc), 32'd0);
        check("wb_rst_cnt", instr_count, 32'd0);
        check("wb_rst_state", 32'(dbg_state), 32'(ST_FETCH));
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Halt at pc=7.
        for (int k = 0; k < 7; k++) do_noop();
        check("pre_halt_pc", 32'(pc), 32'd7);
        fetch(I_HALT);
        tick();
        check("halt_state", 32'(dbg_state), 32'(ST_HALTED));
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'd8);
        check("halt_cnt", instr_count, 32'd8);
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            check("halt_req", 32'(mem_req), 32'd0);
            check("halt_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
            check("halt_hold_pc", 32'(pc), 32'd8);
            check("halt_sticky", 32'(halted), 32'd1);
        end
        check("halt_cnt_hold", instr_count, 32'd8);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
